// File: rtl/lut_neuron_layer_pipe.sv
// Layer of quantised LUT neurons with runtime-loadable truth tables held in registers.
// Latency: 2 cycles from input acceptance to out_valid (S1 input register, S2 lookup register).
// Backpressure: out_ready stalls S2, S1 fills behind it, then in_ready drops; cfg writes never stall.
module lut_neuron_layer_pipe #(
    parameter int NUM_NEURONS = 4,
    parameter int FANIN       = 2,
    parameter int IN_BITS     = 2,
    parameter int OUT_BITS    = 2,
    parameter logic [OUT_BITS-1:0] RESET_ENTRY = '0,
    localparam int ADDR_W = FANIN * IN_BITS,
    localparam int DEPTH  = 1 << ADDR_W,
    localparam int NID_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    input  logic [NID_W-1:0]                cfg_neuron,
    input  logic [ADDR_W-1:0]               cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    output logic                            cfg_err
);

    localparam logic [NID_W:0] NEURON_LIMIT = (NID_W+1)'(NUM_NEURONS);

    logic [OUT_BITS-1:0]             lut_q [NUM_NEURONS][DEPTH];
    logic                            s1_valid;
    logic [NUM_NEURONS*ADDR_W-1:0]   s1_data;
    logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
    logic                            s1_adv;
    logic                            s2_adv;
    logic                            cfg_oor;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign cfg_oor  = ({1'b0, cfg_neuron} >= NEURON_LIMIT);

    // Asynchronous read of the S1 vector; a write on the same edge lands after this sample.
    always_comb begin
        lookup = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            lookup[n*OUT_BITS +: OUT_BITS] = lut_q[n][s1_data[n*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    lut_q[n][a] <= RESET_ENTRY;
                end
            end
            cfg_err <= 1'b0;
        end else begin
            if (cfg_we && !cfg_oor) begin
                lut_q[cfg_neuron][cfg_addr] <= cfg_data;
            end
            cfg_err <= cfg_we && cfg_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= lookup;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Scoreboarded bench for lut_neuron_layer_pipe with a 3-neuron layer and a table-array reference model.
module tb_lut_neuron_layer_pipe;

    localparam int NN    = 3;
    localparam int AW    = 4;
    localparam int OB    = 2;
    localparam int DEPTH = 16;
    localparam int NID_W = 2;
    localparam logic [OB-1:0] RST_E = 2'b01;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NN*AW-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NN*OB-1:0]  out_data;
    logic              cfg_we = 1'b0;
    logic [NID_W-1:0]  cfg_neuron = '0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [OB-1:0]     cfg_data = '0;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic done = 1'b0;

    logic [OB-1:0]    tbl [NN][DEPTH];
    logic [NN*OB-1:0] expq [$];

    always #5 clk = ~clk;

    lut_neuron_layer_pipe #(
        .NUM_NEURONS(NN), .FANIN(2), .IN_BITS(2), .OUT_BITS(OB), .RESET_ENTRY(RST_E)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NN; n++)
            for (int a = 0; a < DEPTH; a++)
                tbl[n][a] = RST_E;
    endtask

    function automatic logic [NN*OB-1:0] model(input logic [NN*AW-1:0] v);
        logic [NN*OB-1:0] r;
        r = '0;
        for (int n = 0; n < NN; n++) r[n*OB +: OB] = tbl[n][v[n*AW +: AW]];
        return r;
    endfunction

    function automatic logic [NN*AW-1:0] rand_vec();
        logic [31:0] r;
        r = $urandom;
        return r[NN*AW-1:0];
    endfunction

    // Offers one vector; the expectation is taken when acceptance is certain.
    task automatic send(input logic [NN*AW-1:0] v);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                break;
            end
        end
        if (in_ready) begin
            expq.push_back(model(v));
            accepted++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_wr(input int n, input int a, input int d);
        cfg_we     = 1'b1;
        cfg_neuron = n[NID_W-1:0];
        cfg_addr   = a[AW-1:0];
        cfg_data   = d[OB-1:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (n < NN) tbl[n][a] = d[OB-1:0];
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d required=0", expq.size());
        end
    endtask

    // Monitor: pops on every output handshake and checks that stalled outputs hold.
    logic             prev_stall = 1'b0;
    logic [NN*OB-1:0] prev_dat = '0;
    always @(negedge clk) begin
        logic [NN*OB-1:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_data", 32'(out_data), 32'(prev_dat));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_data);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NN*AW-1:0] va;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Latency: all-zero vector, every neuron returns the reset entry.
        send('0);
        chk("latency_e0_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("latency_e1_valid", 32'(out_valid), 32'd1);
        chk("reset_entry_data", 32'(out_data), 32'h15);
        drain();

        // Table load and lookup on neuron 0.
        cfg_wr(0, 4'b0000, 2'b10);
        cfg_wr(0, 4'b1000, 2'b11);
        cfg_wr(0, 4'b0100, 2'b00);
        va = rand_vec(); va[3:0] = 4'b1000;
        send(va);
        drain();
        chk("lookup_n0_1000", 32'(out_data[1:0]), 32'd3);
        va = rand_vec(); va[3:0] = 4'b0000;
        send(va);
        drain();
        chk("lookup_n0_0000", 32'(out_data[1:0]), 32'd2);

        // Backpressure: four vectors offered against a blocked output.
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rand_vec());
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("bp_accepted", 32'(accepted), 32'd2);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total", 32'(accepted), 32'd4);

        // Randomised tables then randomised streaming with random backpressure.
        for (int n = 0; n < NN; n++)
            for (int a = 0; a < DEPTH; a++)
                cfg_wr(n, a, int'($urandom_range(3)));
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(rand_vec());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(1) == 1);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Write/lookup race on neuron 1 entry 0011.
        cfg_wr(1, 4'b0011, 2'b00);
        va = rand_vec(); va[7:4] = 4'b0011;
        in_valid = 1'b1;
        in_data  = va;
        @(negedge clk);
        chk("race_ready_a", 32'(in_ready), 32'd1);
        expq.push_back(model(va));
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 4'b0011; cfg_data = 2'b11;
        tbl[1][3] = 2'b11;
        @(negedge clk);
        chk("race_ready_b", 32'(in_ready), 32'd1);
        expq.push_back(model(va));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chk("race_first_result", 32'(out_data[3:2]), 32'd0);
        @(posedge clk); #1;
        chk("race_second_result", 32'(out_data[3:2]), 32'd3);
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(rand_vec());
        send(rand_vec());
        rst_n = 1'b0;
        expq.delete();
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_stale", 32'(out_valid), 32'd0);
        send(rand_vec());
        drain();
        chk("midrst_tables_reset", 32'(out_data), 32'h15);

        // Out-of-range neuron write.
        cfg_we = 1'b1; cfg_neuron = 2'd3; cfg_addr = 4'd5; cfg_data = 2'b10;
        @(negedge clk);
        chk("cfg_err_before", 32'(cfg_err), 32'd0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        @(posedge clk); #1;
        chk("cfg_err_clear", 32'(cfg_err), 32'd0);
        send({4'd5, 4'd5, 4'd5});
        drain();
        chk("cfg_err_tables_kept", 32'(out_data), 32'h15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
